// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Provides the FSM state enum, owner bit positions and grant width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    localparam int GW = 3;

    localparam int OWN_LD = 0;
    localparam int OWN_D  = 1;
    localparam int OWN_F  = 2;

endpackage

// File: rtl/arb_select.sv
// Combinational winner pick: loader > data > fetch, fetch beats data when starved.
// In: ld_req, d_req, f_req, starve_cnt. Out: win (one-hot, GW bits).
module arb_select
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 3,
    parameter int SW         = 2
) (
    input  logic          ld_req,
    input  logic          d_req,
    input  logic          f_req,
    input  logic [SW-1:0] starve_cnt,
    output logic [GW-1:0] win
);

    logic starved;

    assign starved = f_req && (starve_cnt == SW'(STARVE_MAX));

    always_comb begin
        win = '0;
        if (ld_req) begin
            win[OWN_LD] = 1'b1;
        end else if (starved) begin
            win[OWN_F] = 1'b1;
        end else if (d_req) begin
            win[OWN_D] = 1'b1;
        end else if (f_req) begin
            win[OWN_F] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port RAM among loader, data and fetch.
// Ports: three requester payloads in; gnt/done/rdata/busy out; m_* memory port.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic [GW-1:0] gnt,
    output logic [GW-1:0] done,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    arb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] own_q, own_d;
    logic          we_q, we_d;
    logic [SW-1:0] starve_q, starve_d;

    logic [GW-1:0] gnt_d, done_d;
    logic [DW-1:0] rdata_d;
    logic          busy_d, m_en_d, m_we_d;
    logic [AW-1:0] m_addr_d;
    logic [DW-1:0] m_wdata_d;

    logic [GW-1:0] win;
    logic [AW-1:0] sel_addr;
    logic          sel_we;
    logic [DW-1:0] sel_wdata;

    arb_select #(
        .STARVE_MAX(STARVE_MAX),
        .SW        (SW)
    ) u_sel (
        .ld_req    (ld_req),
        .d_req     (d_req),
        .f_req     (f_req),
        .starve_cnt(starve_q),
        .win       (win)
    );

    // Fetch never writes, so its wdata just keeps the port value.
    always_comb begin
        sel_addr  = f_addr;
        sel_we    = 1'b0;
        sel_wdata = m_wdata;
        unique case (1'b1)
            win[OWN_LD]: begin
                sel_addr  = ld_addr;
                sel_we    = ld_we;
                sel_wdata = ld_wdata;
            end
            win[OWN_D]: begin
                sel_addr  = d_addr;
                sel_we    = d_we;
                sel_wdata = d_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        own_d     = own_q;
        we_d      = we_q;
        starve_d  = starve_q;
        gnt_d     = '0;
        done_d    = '0;
        m_en_d    = 1'b0;
        m_we_d    = 1'b0;
        m_addr_d  = m_addr;
        m_wdata_d = m_wdata;
        rdata_d   = rdata;
        busy_d    = busy;
        unique case (state_q)
            IDLE: begin
                if (|win) begin
                    state_d   = ISSUE;
                    own_d     = win;
                    we_d      = sel_we;
                    gnt_d     = win;
                    m_en_d    = 1'b1;
                    m_we_d    = sel_we;
                    m_addr_d  = sel_addr;
                    m_wdata_d = sel_wdata;
                    busy_d    = 1'b1;
                    if (win[OWN_F]) begin
                        starve_d = '0;
                    end else if (win[OWN_D] && f_req &&
                                 starve_q != SW'(STARVE_MAX)) begin
                        starve_d = starve_q + SW'(1);
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CW'(MEM_LAT - 1);
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = own_q;
                    busy_d  = 1'b0;
                    if (!we_q) begin
                        rdata_d = m_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            own_q    <= '0;
            we_q     <= 1'b0;
            starve_q <= '0;
            gnt      <= '0;
            done     <= '0;
            rdata    <= '0;
            busy     <= 1'b0;
            m_en     <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            own_q    <= own_d;
            we_q     <= we_d;
            starve_q <= starve_d;
            gnt      <= gnt_d;
            done     <= done_d;
            rdata    <= rdata_d;
            busy     <= busy_d;
            m_en     <= m_en_d;
            m_we     <= m_we_d;
            m_addr   <= m_addr_d;
            m_wdata  <= m_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model.
// Drives three requester agents and a latency-2 RAM; checks every cycle.
module tb_mem_port_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 3;
    localparam int NC   = 2600;
    localparam int NA   = NC + 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_req, ld_we, d_req, d_we, f_req;
    logic [AW-1:0] ld_addr, d_addr, f_addr;
    logic [DW-1:0] ld_wdata, d_wdata;
    logic [2:0]    gnt, done;
    logic [DW-1:0] rdata;
    logic          busy, m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .ld_req(ld_req), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .d_req(d_req), .d_we(d_we),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .f_req(f_req), .f_addr(f_addr),
        .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // Physical RAM: read data shows up LAT cycles after m_en, noise otherwise.
    logic [DW-1:0] mem [256];
    logic          p_v;
    logic [DW-1:0] p_d;

    always @(posedge clk) begin
        if (m_en && m_we) mem[m_addr] <= m_wdata;
        p_v     <= m_en && !m_we;
        p_d     <= mem[m_addr];
        m_rdata <= p_v ? p_d : DW'($urandom);
    end

    int cyc;
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag,
                         input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc %0d got %h want %h", tag, cyc, obs, exp);
        end
    endtask

    // Expected per-cycle observations, filled when the model grants.
    logic [2:0]    e_gnt  [NA];
    logic [2:0]    e_done [NA];
    logic          e_busy [NA];
    logic          e_we   [NA];
    logic          e_rdv  [NA];
    logic [AW-1:0] e_addr [NA];
    logic [DW-1:0] e_wd   [NA];
    logic [DW-1:0] e_rd   [NA];
    logic [DW-1:0] shadow [256];
    logic [DW-1:0] h_rdata;
    int            next_arb, last_k, ms, next_rst;

    bit            pend [3];
    bit            infl [3];
    logic          rwe  [3];
    logic [AW-1:0] raddr[3];
    logic [DW-1:0] rwd  [3];

    task automatic clear_future(input int from);
        for (int j = from; j < NA; j++) begin
            e_gnt[j]  = '0;
            e_done[j] = '0;
            e_busy[j] = 1'b0;
            e_we[j]   = 1'b0;
            e_rdv[j]  = 1'b0;
            e_addr[j] = '0;
            e_wd[j]   = '0;
            e_rd[j]   = '0;
        end
    endtask

    task automatic raise(input int i, input logic [AW-1:0] a,
                         input logic we, input logic [DW-1:0] wd);
        if (!pend[i] && !infl[i]) begin
            pend[i]  = 1'b1;
            raddr[i] = a;
            rwe[i]   = (i == 2) ? 1'b0 : we;
            rwd[i]   = wd;
        end
    endtask

    task automatic drive();
        ld_req   = pend[0];
        ld_we    = rwe[0];
        ld_addr  = raddr[0];
        ld_wdata = rwd[0];
        d_req    = pend[1];
        d_we     = rwe[1];
        d_addr   = raddr[1];
        d_wdata  = rwd[1];
        f_req    = pend[2];
        f_addr   = raddr[2];
    endtask

    // One transaction every LAT+2 cycles; loader first, starved fetch next.
    task automatic model_arb(input int c);
        int i;
        if (c < next_arb) return;
        if (!(pend[0] || pend[1] || pend[2])) return;
        if (pend[0]) i = 0;
        else if (pend[2] && ms == SMAX) i = 2;
        else if (pend[1]) i = 1;
        else i = 2;
        if (i == 1 && pend[2] && ms < SMAX) ms++;
        if (i == 2) ms = 0;
        e_gnt[c+1]  = 3'(1 << i);
        e_we[c+1]   = rwe[i];
        e_addr[c+1] = raddr[i];
        e_wd[c+1]   = rwd[i];
        for (int j = 1; j <= LAT + 1; j++) e_busy[c+j] = 1'b1;
        e_done[c+LAT+2] = 3'(1 << i);
        if (rwe[i]) begin
            shadow[raddr[i]] = rwd[i];
        end else begin
            e_rdv[c+LAT+2] = 1'b1;
            e_rd[c+LAT+2]  = shadow[raddr[i]];
        end
        next_arb = c + LAT + 2;
        last_k   = c;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_gnt"},   DW'(gnt),   '0);
        check({pfx, "_done"},  DW'(done),  '0);
        check({pfx, "_rdata"}, rdata,      '0);
        check({pfx, "_busy"},  DW'(busy),  '0);
        check({pfx, "_m_en"},  DW'(m_en),  '0);
        check({pfx, "_m_we"},  DW'(m_we),  '0);
        check({pfx, "_addr"},  DW'(m_addr), '0);
        check({pfx, "_wdata"}, m_wdata,    '0);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        return AW'($urandom_range(31));
    endfunction

    initial begin
        logic [DW-1:0] v;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pend[i]  = 1'b0;
            infl[i]  = 1'b0;
            rwe[i]   = 1'b0;
            raddr[i] = '0;
            rwd[i]   = '0;
        end
        drive();
        for (int i = 0; i < 256; i++) begin
            v = (i == 16) ? 32'h8C01_0004 : DW'($urandom);
            mem[i]   <= v;
            shadow[i] = v;
        end
        clear_future(0);
        h_rdata  = '0;
        next_arb = 0;
        last_k   = -100;
        ms       = 0;
        next_rst = 1900;
        cyc      = -1;

        repeat (3) @(posedge clk);
        #1;
        check_zero("rst");
        #2 rst = 1'b1;

        cyc = 0;
        while (cyc < NC) begin
            @(posedge clk);
            #1;
            if (e_rdv[cyc]) h_rdata = e_rd[cyc];
            check("gnt",   DW'(gnt),  DW'(e_gnt[cyc]));
            check("done",  DW'(done), DW'(e_done[cyc]));
            check("m_en",  DW'(m_en), DW'(e_gnt[cyc] != 3'b000));
            check("m_we",  DW'(m_we), DW'(e_gnt[cyc] != 3'b000 && e_we[cyc]));
            check("busy",  DW'(busy), DW'(e_busy[cyc]));
            check("rdata", rdata, h_rdata);
            if (e_gnt[cyc] != 3'b000) begin
                check("m_addr", DW'(m_addr), DW'(e_addr[cyc]));
                if (e_we[cyc]) check("m_wdata", m_wdata, e_wd[cyc]);
            end
            if (cyc == 4) check("tp_fetch_rd", rdata, 32'h8C01_0004);
            if (cyc == 8) check("tp_wr_keep", rdata, 32'h8C01_0004);

            for (int i = 0; i < 3; i++) begin
                if (gnt[i] && pend[i]) begin
                    pend[i] = 1'b0;
                    infl[i] = 1'b1;
                end
                if (done[i]) infl[i] = 1'b0;
            end

            // Abort a transaction in its first WAIT cycle.
            if (cyc >= next_rst && cyc == last_k + 2) begin
                #1 rst = 1'b0;
                #1;
                check_zero("midrst");
                clear_future(cyc + 1);
                h_rdata  = '0;
                ms       = 0;
                next_arb = cyc;
                for (int i = 0; i < 3; i++) infl[i] = 1'b0;
                next_rst = cyc + 150;
                #1 rst = 1'b1;
            end

            if (cyc < 24) begin
                if (cyc == 0) raise(2, 8'h10, 1'b0, '0);
                if (cyc == 4) raise(1, 8'h20, 1'b1, 32'hDEAD_BEEF);
                if (cyc == 8) begin
                    raise(0, 8'h30, 1'b0, '0);
                    raise(1, 8'h20, 1'b0, '0);
                    raise(2, 8'h10, 1'b0, '0);
                end
            end else if (cyc < 800 || cyc >= 1900) begin
                for (int i = 0; i < 3; i++)
                    if ($urandom_range(2) == 0)
                        raise(i, rnd_addr(), 1'($urandom_range(1)),
                              DW'($urandom));
            end else begin
                raise(1, rnd_addr(), 1'($urandom_range(1)), DW'($urandom));
                raise(2, rnd_addr(), 1'b0, '0);
                if (cyc >= 1400 && $urandom_range(5) == 0)
                    raise(0, rnd_addr(), 1'($urandom_range(1)),
                          DW'($urandom));
            end

            drive();
            model_arb(cyc);
            cyc++;
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
